// File: rtl/sorting_mesh.sv
// Shearsort write-routing mesh: packets sort to their destination PE,
// then each PE commits its packet data once into a local memory register.
module sorting_mesh #(
  parameter int N           = 256,
  parameter int SQRT_N      = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int SORT_CYCLES = 112
) (
  input logic clk,
  input logic rst
);

  localparam int CW         = $clog2(SORT_CYCLES + 1);
  localparam int LAST_PHASE = SORT_CYCLES / SQRT_N - 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

  pkt_t                  pkt_q [N];
  pkt_t                  pkt_d [N];
  logic [DATA_WIDTH-1:0] mem   [N];
  logic [CW-1:0]         counter;
  logic                  done;

  int   phase;
  int   step;
  logic row_ph;
  logic last_ph;
  int   lo;
  int   hi;
  logic asc;
  logic swp;

  // Decode the current phase (row/column) and step parity from the counter
  always_comb begin
    phase   = int'(counter) / SQRT_N;
    step    = int'(counter) % SQRT_N;
    row_ph  = (phase % 2) == 0;
    last_ph = phase == LAST_PHASE;
  end

  // One odd-even transposition step across every row or every column
  always_comb begin
    pkt_d = pkt_q;
    lo    = 0;
    hi    = 0;
    asc   = 1'b1;
    swp   = 1'b0;
    for (int l = 0; l < SQRT_N; l++) begin
      for (int j = 0; j < SQRT_N - 1; j++) begin
        if ((j % 2) == (step % 2)) begin
          lo  = row_ph ? l * SQRT_N + j : j * SQRT_N + l;
          hi  = row_ph ? lo + 1 : lo + SQRT_N;
          asc = !row_ph || last_ph || ((l % 2) == 0);
          swp = asc ? (pkt_q[lo].addr > pkt_q[hi].addr)
                    : (pkt_q[lo].addr < pkt_q[hi].addr);
          if (swp) begin
            pkt_d[lo] = pkt_q[hi];
            pkt_d[hi] = pkt_q[lo];
          end
        end
      end
    end
  end

  // Load, sort for SORT_CYCLES steps, write once, then hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      counter <= '0;
      done    <= 1'b0;
      for (int k = 0; k < N; k++) begin
        pkt_q[k].addr <= ADDR_WIDTH'(N - 1 - k);
        pkt_q[k].data <= DATA_WIDTH'(k);
        mem[k]        <= '0;
      end
    end else if (!done) begin
      if (counter == CW'(SORT_CYCLES)) begin
        done <= 1'b1;
        for (int k = 0; k < N; k++) begin
          if (pkt_q[k].addr == ADDR_WIDTH'(k)) begin
            mem[k] <= pkt_q[k].data;
          end
        end
      end else begin
        counter <= counter + 1'b1;
        for (int k = 0; k < N; k++) begin
          pkt_q[k] <= pkt_d[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_sorting_mesh.sv
// Bench for sorting_mesh: randomized reset timing, scoreboarded
// completion events, and reference-model checks at two mesh sizes.
module tb_sorting_mesh;

  localparam int BN = 256;
  localparam int BS = 16;
  localparam int BC = 112;
  localparam int SN = 16;
  localparam int SS = 4;
  localparam int SC = 28;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sorting_mesh #(
    .N(BN), .SQRT_N(BS), .ADDR_WIDTH(8),
    .DATA_WIDTH(8), .SORT_CYCLES(BC)
  ) dut_b (
    .clk(clk),
    .rst(rst)
  );

  sorting_mesh #(
    .N(SN), .SQRT_N(SS), .ADDR_WIDTH(4),
    .DATA_WIDTH(8), .SORT_CYCLES(SC)
  ) dut_s (
    .clk(clk),
    .rst(rst)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int rst_edges = 0;
  int q_b[$];
  int q_s[$];
  logic done_b_d = 1'b0;
  logic done_s_d = 1'b0;
  int snap_b [BN];

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: init packet j is {addr n-1-j, data j}; the packet that
  // must end up at PE k is the one whose addr is k.
  function automatic int ref_data(int n, int k);
    for (int j = 0; j < n; j++)
      if ((n - 1 - j) == k) return j % 256;
    return -1;
  endfunction

  function automatic int bad_mem_b(bit zero);
    int n = 0;
    for (int k = 0; k < BN; k++)
      if (int'(dut_b.mem[k]) != (zero ? 0 : ref_data(BN, k))) n++;
    return n;
  endfunction

  function automatic int bad_mem_s(bit zero);
    int n = 0;
    for (int k = 0; k < SN; k++)
      if (int'(dut_s.mem[k]) != (zero ? 0 : ref_data(SN, k))) n++;
    return n;
  endfunction

  function automatic int bad_pkt_b();
    int n = 0;
    for (int k = 0; k < BN; k++)
      if (int'(dut_b.pkt_q[k].addr) != k ||
          int'(dut_b.pkt_q[k].data) != ref_data(BN, k)) n++;
    return n;
  endfunction

  function automatic int bad_pkt_s();
    int n = 0;
    for (int k = 0; k < SN; k++)
      if (int'(dut_s.pkt_q[k].addr) != k ||
          int'(dut_s.pkt_q[k].data) != ref_data(SN, k)) n++;
    return n;
  endfunction

  // Row 0 after phase 0 must be its initial addrs sorted ascending
  function automatic int bad_row0_b();
    int q[$];
    int n = 0;
    for (int c = 0; c < BS; c++) q.push_back(BN - 1 - c);
    q.sort();
    for (int c = 0; c < BS; c++)
      if (int'(dut_b.pkt_q[c].addr) != q[c] ||
          int'(dut_b.pkt_q[c].data) != BN - 1 - q[c]) n++;
    return n;
  endfunction

  // Edge count since reset release, derived from the bench's own rst
  always @(posedge clk) begin
    if (!rst) begin
      cyc       <= 0;
      rst_edges <= rst_edges + 1;
    end else begin
      cyc       <= cyc + 1;
      rst_edges <= 0;
    end
  end

  // Monitor: in-flight checks and scoreboard pops on completion
  always @(negedge clk) begin
    if (!rst && rst_edges >= 1) begin
      check("reset_mem_b", bad_mem_b(1'b1), 0);
      check("reset_mem_s", bad_mem_s(1'b1), 0);
      check("reset_done_b", int'(dut_b.done), 0);
    end
    if (rst) begin
      if (cyc == BS) check("row0_phase0_b", bad_row0_b(), 0);
      if (cyc == BC) begin
        check("prewrite_mem_b", bad_mem_b(1'b1), 0);
        check("sorted_pkt_b", bad_pkt_b(), 0);
      end
      if (cyc == SC) begin
        check("prewrite_mem_s", bad_mem_s(1'b1), 0);
        check("sorted_pkt_s", bad_pkt_s(), 0);
      end
      if (dut_b.done && !done_b_d) begin
        if (q_b.size() == 0) begin
          check("unexpected_done_b", 1, 0);
        end else begin
          check("latency_b", cyc, q_b.pop_front());
          check("final_mem_b", bad_mem_b(1'b0), 0);
        end
      end
      if (dut_s.done && !done_s_d) begin
        if (q_s.size() == 0) begin
          check("unexpected_done_s", 1, 0);
        end else begin
          check("latency_s", cyc, q_s.pop_front());
          check("final_mem_s", bad_mem_s(1'b0), 0);
        end
      end
    end
    done_b_d <= dut_b.done;
    done_s_d <= dut_s.done;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_release(int hold);
    rst = 1'b0;
    q_b.delete();
    q_s.delete();
    tick(hold);
    q_b.push_back(BC + 1);
    q_s.push_back(SC + 1);
    rst = 1'b1;
  endtask

  // Stimulus: randomized reset lengths, mid-sort restarts and hold times
  initial begin
    int at;
    int hold_n;
    int bad;
    #1;
    for (int t = 0; t < 4; t++) begin
      reset_release(t == 0 ? 2 : int'($urandom_range(2, 5)));
      at = (t == 1) ? 50 : (t == 3) ? int'($urandom_range(1, BC)) : 0;
      if (at > 0) begin
        tick(at);
        reset_release(int'($urandom_range(1, 3)));
      end
      for (int i = 0; i < 400 && (q_b.size() != 0 || q_s.size() != 0); i++)
        tick(1);
      check("done_timeout", q_b.size() + q_s.size(), 0);
      for (int k = 0; k < BN; k++) snap_b[k] = int'(dut_b.mem[k]);
      hold_n = (t == 2) ? 1000 : int'($urandom_range(5, 60));
      tick(hold_n);
      bad = 0;
      for (int k = 0; k < BN; k++)
        if (int'(dut_b.mem[k]) != snap_b[k]) bad++;
      check("hold_mem_b", bad, 0);
      check("hold_final_b", bad_mem_b(1'b0), 0);
      check("hold_final_s", bad_mem_s(1'b0), 0);
      check("hold_counter_b", int'(dut_b.counter), BC);
      check("hold_done_b", int'(dut_b.done), 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
